// File: rtl/efuse_pkg.sv
// Shared efuse read/program definitions: widths, read FSM states and the timing clamp.
// Used by efuse_rd_seq and the program-path sequencer.
package efuse_pkg;

    localparam int EFUSE_ADDR_W = 8;
    localparam int EFUSE_DATA_W = 8;
    localparam int EFUSE_TCNT_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } efuse_rd_state_t;

    // A programmed timing of zero still needs one cycle of the phase.
    function automatic logic [EFUSE_TCNT_W-1:0] rd_clamp(input logic [EFUSE_TCNT_W-1:0] x);
        return (x == '0) ? EFUSE_TCNT_W'(1) : x;
    endfunction

endpackage

// File: rtl/efuse_tcnt.sv
// Phase cycle counter: clear/load/enable, saturates instead of wrapping; tc when count equals term.
// Zero latency on tc (combinational compare of the registered count); no backpressure.
module efuse_tcnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/efuse_rd_seq.sv
// efuse read sequencer: RDEN+address setup, timed AEN strobe, capture; S+T+1 cycles per byte, outputs registered.
// No backpressure: requests while busy/blocked are dropped with rd_err. Auto-load is built only with EFUSE_AUTOLOAD_EN.
module efuse_rd_seq
    import efuse_pkg::*;
#(
    parameter int ADDR_W    = EFUSE_ADDR_W,
    parameter int DATA_W    = EFUSE_DATA_W,
    parameter int NUM_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rg_efuse_reg_mode,
    input  logic              rg_efuse_pgmen,
    input  logic              rg_efuse_rd_req,
    input  logic [ADDR_W-1:0] rg_efuse_rd_addr,
    input  logic [3:0]        rg_efuse_tsu,
    input  logic [9:0]        rg_efuse_trd,
    input  logic [DATA_W-1:0] efuse_dout,
    output logic              efuse_rden,
    output logic              efuse_aen,
    output logic [ADDR_W-1:0] efuse_addr,
    output logic [DATA_W-1:0] rg_efuse_rd_data,
    output logic              rg_efuse_rd_done,
    output logic              rg_efuse_rd_err,
    output logic              rg_efuse_rd_busy,
    output logic              shadow_we,
    output logic [ADDR_W-1:0] shadow_waddr,
    output logic [DATA_W-1:0] shadow_wdata,
    output logic              autoload_done
);
    efuse_rd_state_t         state, state_nxt;
    logic [EFUSE_TCNT_W-1:0] s_lim, t_lim, term;
    logic                    tc, accept, capture, enter_setup;
    logic                    al_run, al_start, al_more;
    logic [ADDR_W-1:0]       addr_nxt;
    logic                    rden_nxt, aen_nxt, done_nxt, err_nxt;

`ifdef EFUSE_AUTOLOAD_EN
    localparam logic [ADDR_W-1:0] AL_LAST = ADDR_W'(NUM_WORDS - 1);

    logic              al_go, al_done;
    logic [ADDR_W-1:0] al_addr;

    // al_addr always points at the next byte to fetch, whether resuming from IDLE or chaining from HOLD.
    assign al_run   = !al_done;
    assign al_start = al_go && al_run && !rg_efuse_pgmen;
    assign al_more  = al_run && (efuse_addr != AL_LAST) && !rg_efuse_pgmen;
    assign addr_nxt = al_run ? al_addr : rg_efuse_rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_go        <= 1'b0;
            al_done      <= 1'b0;
            al_addr      <= '0;
            shadow_we    <= 1'b0;
            shadow_waddr <= '0;
            shadow_wdata <= '0;
        end else begin
            al_go     <= 1'b1;
            shadow_we <= capture && al_run;
            if (enter_setup && al_run) begin
                al_addr <= addr_nxt + ADDR_W'(1);
            end
            if ((state == HOLD) && (state_nxt == IDLE) && al_run && (efuse_addr == AL_LAST)) begin
                al_done <= 1'b1;
            end
            if (capture && al_run) begin
                shadow_waddr <= efuse_addr;
                shadow_wdata <= efuse_dout;
            end
        end
    end

    assign autoload_done = al_done;
`else
    assign al_run       = 1'b0;
    assign al_start     = 1'b0;
    assign al_more      = 1'b0;
    assign addr_nxt     = rg_efuse_rd_addr;
    assign shadow_we    = 1'b0;
    assign shadow_waddr = '0;
    assign shadow_wdata = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            autoload_done <= 1'b0;
        end else begin
            autoload_done <= 1'b1;
        end
    end
`endif

    assign accept = (state == IDLE) && rg_efuse_rd_req && rg_efuse_reg_mode
                    && !rg_efuse_pgmen && !al_run;
    assign term   = (state == STROBE) ? (t_lim - EFUSE_TCNT_W'(1)) : (s_lim - EFUSE_TCNT_W'(1));

    efuse_tcnt #(.W(EFUSE_TCNT_W)) u_tcnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_nxt != state),
        .ld     (1'b0),
        .ld_val ('0),
        .en     ((state == SETUP) || (state == STROBE)),
        .term   (term),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (al_start || accept) state_nxt = SETUP;
            SETUP:   if (tc) state_nxt = STROBE;
            STROBE:  if (tc) state_nxt = HOLD;
            HOLD:    state_nxt = al_more ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pin values are computed from the next state so every output comes straight from a flop.
    always_comb begin
        enter_setup = (state_nxt == SETUP) && (state != SETUP);
        capture     = (state == STROBE) && (state_nxt == HOLD);
        rden_nxt    = (state_nxt != IDLE);
        aen_nxt     = (state_nxt == STROBE);
        done_nxt    = capture && !al_run;
        err_nxt     = rg_efuse_rd_req && !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            efuse_rden       <= 1'b0;
            efuse_aen        <= 1'b0;
            efuse_addr       <= '0;
            rg_efuse_rd_data <= '0;
            rg_efuse_rd_done <= 1'b0;
            rg_efuse_rd_err  <= 1'b0;
            rg_efuse_rd_busy <= 1'b0;
            s_lim            <= '0;
            t_lim            <= '0;
        end else begin
            efuse_rden       <= rden_nxt;
            efuse_aen        <= aen_nxt;
            rg_efuse_rd_done <= done_nxt;
            rg_efuse_rd_err  <= err_nxt;
            rg_efuse_rd_busy <= rden_nxt;
            if (enter_setup) begin
                efuse_addr <= addr_nxt;
                s_lim      <= rd_clamp(EFUSE_TCNT_W'(rg_efuse_tsu));
                t_lim      <= rd_clamp(rg_efuse_trd);
            end
            if (done_nxt) begin
                rg_efuse_rd_data <= efuse_dout;
            end
        end
    end

endmodule

// File: tb/tb_efuse_rd_seq.sv
// Scoreboard bench for efuse_rd_seq: randomized single reads against a cycle-level access model;
// auto-load scenarios are exercised when EFUSE_AUTOLOAD_EN is defined.
`timescale 1ns/1ps
module tb_efuse_rd_seq;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rg_efuse_reg_mode, rg_efuse_pgmen, rg_efuse_rd_req;
    logic [AW-1:0] rg_efuse_rd_addr;
    logic [3:0]    rg_efuse_tsu;
    logic [9:0]    rg_efuse_trd;
    logic [DW-1:0] efuse_dout;
    logic          efuse_rden, efuse_aen;
    logic [AW-1:0] efuse_addr;
    logic [DW-1:0] rg_efuse_rd_data;
    logic          rg_efuse_rd_done, rg_efuse_rd_err, rg_efuse_rd_busy;
    logic          shadow_we;
    logic [AW-1:0] shadow_waddr;
    logic [DW-1:0] shadow_wdata;
    logic          autoload_done;

    efuse_rd_seq #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rg_efuse_reg_mode(rg_efuse_reg_mode), .rg_efuse_pgmen(rg_efuse_pgmen),
        .rg_efuse_rd_req(rg_efuse_rd_req), .rg_efuse_rd_addr(rg_efuse_rd_addr),
        .rg_efuse_tsu(rg_efuse_tsu), .rg_efuse_trd(rg_efuse_trd),
        .efuse_dout(efuse_dout), .efuse_rden(efuse_rden), .efuse_aen(efuse_aen),
        .efuse_addr(efuse_addr), .rg_efuse_rd_data(rg_efuse_rd_data),
        .rg_efuse_rd_done(rg_efuse_rd_done), .rg_efuse_rd_err(rg_efuse_rd_err),
        .rg_efuse_rd_busy(rg_efuse_rd_busy), .shadow_we(shadow_we),
        .shadow_waddr(shadow_waddr), .shadow_wdata(shadow_wdata),
        .autoload_done(autoload_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fuse array model: data only valid while the strobe is high.
    logic [DW-1:0] fuse_mem [256];
    assign efuse_dout = efuse_aen ? fuse_mem[efuse_addr] : ~fuse_mem[efuse_addr];

    typedef struct { int due; int aen_at; logic [AW-1:0] addr; logic [DW-1:0] data; int s; int t; } rd_exp_t;
    typedef struct { int at; logic rden; logic [AW-1:0] addr; bit pins; } err_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int s; int t; } sh_exp_t;

    rd_exp_t  rd_q [$];
    err_exp_t err_q [$];
    sh_exp_t  sh_q [$];

    int checks = 0;
    int errors = 0;

    int            free_at = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s unexpected pulse actual=1 required=0 (cycle %0d)", name, cyc);
    endtask

    function automatic int clamp1(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle request and records what the spec says must come back.
    task automatic issue(input logic [AW-1:0] addr, input logic mode, input logic pg,
                         input logic [3:0] tsu, input logic [9:0] trd, input bit al_busy);
        int s, t;
        rd_exp_t  re;
        err_exp_t ee;
        rg_efuse_rd_req   = 1'b1;
        rg_efuse_rd_addr  = addr;
        rg_efuse_reg_mode = mode;
        rg_efuse_pgmen    = pg;
        rg_efuse_tsu      = tsu;
        rg_efuse_trd      = trd;
        s = clamp1(int'(tsu));
        t = clamp1(int'(trd));
        if (mode && !pg && !al_busy && cyc >= free_at) begin
            re.due = cyc + s + t + 1; re.aen_at = cyc + s + 1;
            re.addr = addr; re.data = fuse_mem[addr]; re.s = s; re.t = t;
            rd_q.push_back(re);
            free_at   = cyc + s + t + 2;
            last_addr = addr;
        end else begin
            ee.at = cyc + 1; ee.rden = (cyc + 1 < free_at); ee.addr = last_addr; ee.pins = !al_busy;
            err_q.push_back(ee);
        end
        @(posedge clk);
        #1;
        rg_efuse_rd_req   = 1'b0;
        rg_efuse_pgmen    = 1'b0;
        rg_efuse_reg_mode = 1'b1;
    endtask

    // Monitor: pops expectations as the DUT presents results.
    int            rden_cnt = 0, aen_cnt = 0, aen_first = -1;
    logic [DW-1:0] mon_last = '0;

    initial begin : monitor
        rd_exp_t  re;
        err_exp_t ee;
        sh_exp_t  se;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rden_cnt = 0; aen_cnt = 0; aen_first = -1; mon_last = '0;
            end else begin
                if (efuse_rden) rden_cnt++;
                if (efuse_aen) begin
                    if (aen_first < 0) aen_first = cyc;
                    aen_cnt++;
                end
                if (rg_efuse_rd_done) begin
                    if (rd_q.size() == 0) unexpected("rd_done");
                    else begin
                        re = rd_q.pop_front();
                        check("rd_done_cycle", cyc, re.due);
                        check("rd_data", 32'(rg_efuse_rd_data), 32'(re.data));
                        check("rden_len", rden_cnt, re.s + re.t + 1);
                        check("aen_len", aen_cnt, re.t);
                        check("aen_rise", aen_first, re.aen_at);
                        check("rd_pin_addr", 32'(efuse_addr), 32'(re.addr));
                        check("busy_in_hold", 32'(rg_efuse_rd_busy), 32'd1);
                        mon_last = re.data;
                    end
                    rden_cnt = 0; aen_cnt = 0; aen_first = -1;
                end
                if (shadow_we) begin
                    if (sh_q.size() == 0) unexpected("shadow_we");
                    else begin
                        se = sh_q.pop_front();
                        check("shadow_waddr", 32'(shadow_waddr), 32'(se.addr));
                        check("shadow_wdata", 32'(shadow_wdata), 32'(se.data));
                        check("al_rden_len", rden_cnt, se.s + se.t + 1);
                        check("al_aen_len", aen_cnt, se.t);
                    end
                    rden_cnt = 0; aen_cnt = 0; aen_first = -1;
                end
                if (rg_efuse_rd_err) begin
                    if (err_q.size() == 0) unexpected("rd_err");
                    else begin
                        ee = err_q.pop_front();
                        check("rd_err_cycle", cyc, ee.at);
                        check("rej_rd_data", 32'(rg_efuse_rd_data), 32'(mon_last));
                        if (ee.pins) begin
                            check("rej_rden", 32'(efuse_rden), 32'(ee.rden));
                            check("rej_addr", 32'(efuse_addr), 32'(ee.addr));
                        end
                    end
                end
            end
        end
    end

`ifdef EFUSE_AUTOLOAD_EN
    task automatic push_al(input int n);
        sh_exp_t se;
        for (int a = 0; a < n; a++) begin
            se.addr = AW'(a); se.data = fuse_mem[a];
            se.s = clamp1(int'(rg_efuse_tsu)); se.t = clamp1(int'(rg_efuse_trd));
            sh_q.push_back(se);
        end
    endtask

    task automatic wait_al_done(input string name);
        int n = 0;
        while (autoload_done !== 1'b1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(autoload_done), 32'd1);
    endtask

    task automatic autoload_phase();
        int n;
        // Pass 1: pgmen stall after address 1, plus a request rejected during auto-load.
        push_al(NW);
        n = 0;
        while (!(shadow_we === 1'b1 && shadow_waddr == AW'(1)) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("wait_shadow_addr1", 32'(n < 200), 32'd1);
        rg_efuse_pgmen = 1'b1;
        idle(10);
        check("stall_rden", 32'(efuse_rden), 32'd0);
        check("stall_busy", 32'(rg_efuse_rd_busy), 32'd0);
        check("stall_not_done", 32'(autoload_done), 32'd0);
        issue(8'h10, 1'b1, 1'b1, 4'd2, 10'd3, 1'b1);
        wait_al_done("autoload_done_stall");
        idle(2);
        check("al_writes_left", sh_q.size(), 0);

        // Pass 2: reset during the strobe of address 2, then a clean restart from 0.
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        push_al(2);
        n = 0;
        while (!(efuse_aen === 1'b1 && efuse_addr == AW'(2)) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("wait_aen_addr2", 32'(n < 200), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_aen_drop", 32'(efuse_aen), 32'd0);
        check("rst_rden_drop", 32'(efuse_rden), 32'd0);
        check("rst_al_done_clr", 32'(autoload_done), 32'd0);
        check("al_writes_before_rst", sh_q.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_al(NW);
        wait_al_done("autoload_done_restart");
        idle(2);
        check("al_restart_writes_left", sh_q.size(), 0);
        last_addr = AW'(NW - 1);
        free_at   = cyc;
    endtask
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [3:0] tsu_r;
        logic [9:0] trd_r;
        rst_n             = 1'b0;
        rg_efuse_reg_mode = 1'b1;
        rg_efuse_pgmen    = 1'b0;
        rg_efuse_rd_req   = 1'b0;
        rg_efuse_rd_addr  = '0;
        rg_efuse_tsu      = 4'd2;
        rg_efuse_trd      = 10'd3;
        for (int i = 0; i < 256; i++) fuse_mem[i] = DW'($urandom);
        for (int i = 0; i < NW; i++) fuse_mem[i] = DW'(i) ^ 8'hFF;
        fuse_mem[8'h3A] = 8'hC5;

        idle(3);
        check("reset_pins", {29'd0, efuse_rden, efuse_aen, rg_efuse_rd_busy}, 32'd0);
        check("reset_addr", 32'(efuse_addr), 32'd0);
        check("reset_rd_data", 32'(rg_efuse_rd_data), 32'd0);
        check("reset_pulses", {30'd0, rg_efuse_rd_done, rg_efuse_rd_err}, 32'd0);
        check("reset_shadow", {15'd0, shadow_we, shadow_waddr, shadow_wdata}, 32'd0);
        check("reset_autoload_done", 32'(autoload_done), 32'd0);
        rst_n = 1'b1;

`ifdef EFUSE_AUTOLOAD_EN
        autoload_phase();
`else
        idle(1);
        check("autoload_done_after_rst", 32'(autoload_done), 32'd1);
`endif

        // Example read: rden 1..8, aen 3..7, done at 8.
        issue(8'h3A, 1'b1, 1'b0, 4'd2, 10'd5, 1'b0);
        idle(10);
        check("example_rd_data", 32'(rg_efuse_rd_data), 32'hC5);

        // Zero timings clamp to one cycle each.
        issue(8'h07, 1'b1, 1'b0, 4'd0, 10'd0, 1'b0);
        idle(4);

        // Rejections: busy, pgmen, register mode off.
        issue(8'h11, 1'b1, 1'b0, 4'd4, 10'd4, 1'b0);
        issue(8'h22, 1'b1, 1'b0, 4'd1, 10'd1, 1'b0);
        idle(12);
        issue(8'h33, 1'b1, 1'b1, 4'd1, 10'd1, 1'b0);
        issue(8'h44, 1'b0, 1'b0, 4'd1, 10'd1, 1'b0);
        idle(2);

        // Back-to-back boundary: reject in HOLD, accept the very next cycle.
        issue(8'h55, 1'b1, 1'b0, 4'd1, 10'd1, 1'b0);
        idle_to(free_at - 1);
        issue(8'h66, 1'b1, 1'b0, 4'd1, 10'd1, 1'b0);
        issue(8'h77, 1'b1, 1'b0, 4'd1, 10'd2, 1'b0);
        idle(8);

        // Random traffic; timing inputs are scrambled mid-access to prove they are sampled once.
        for (int k = 0; k < 60; k++) begin
            idle($urandom_range(0, 10));
            tsu_r = 4'($urandom);
            trd_r = 10'($urandom_range(0, 12));
            issue(AW'($urandom), ($urandom % 8) != 0, ($urandom % 6) == 0, tsu_r, trd_r, 1'b0);
            rg_efuse_tsu = 4'($urandom);
            rg_efuse_trd = 10'($urandom);
        end
        idle(50);

        check("rd_queue_drained", rd_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        check("sh_queue_drained", sh_q.size(), 0);
`ifndef EFUSE_AUTOLOAD_EN
        check("shadow_tied_off", {15'd0, shadow_we, shadow_waddr, shadow_wdata}, 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
